ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 5-stage RISC-V core.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Buffers returned instructions in a small FIFO tagged with their PC and presents them to decode under a valid/ready handshake.
- Applies EX-stage redirects (jump / taken branch) by flushing the FIFO and discarding any stale in-flight response.

---
 rtl/ifetch_ctrl.sv | 114 +++++++++++
 tb/tb_ifetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction-fetch sequencer with fetch buffer and redirect handling
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int PW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FB_DEPTH);

  typedef enum logic [1:0] {RUN, WAIT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic [31:0] redirect_tgt;
  logic [31:0] instr_q [FB_DEPTH];
  logic [31:0] pc_q    [FB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic pop, do_pop, push, fire, space_ok, in_wait;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign in_wait      = (state == WAIT);

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? instr_q[rd_ptr] : 32'h0;
  assign if_pc    = if_valid ? pc_q[rd_ptr]    : 32'h0;

  assign pop    = if_valid & id_ready;
  assign do_pop = pop & ~redirect;

  // The in-flight response already owns a slot, so it counts against space.
  assign occ      = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, in_wait};
  assign space_ok = (occ < DEPTH_V);

  assign imem_req  = ~reset & ~redirect & space_ok &
                     ((state == RUN) | (in_wait & imem_rvalid));
  assign imem_addr = fetch_pc;
  assign fire      = imem_req & imem_gnt;
  assign push      = in_wait & imem_rvalid & ~redirect;

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      case (state)
        WAIT:    state_nxt = imem_rvalid ? RUN : DRAIN;
        DRAIN:   state_nxt = imem_rvalid ? RUN : DRAIN;
        default: state_nxt = RUN;
      endcase
    end else if (fire) begin
      state_nxt = WAIT;
    end else if (imem_rvalid && state != RUN) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'h0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_tgt;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(do_pop);
      end
    end
  end

  // Buffer storage needs no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - directed bench for ifetch_ctrl with a single-outstanding memory model
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  int          n_grants;

  int n_checks = 0;
  int n_errors = 0;

  ifetch_ctrl #(.RESET_PC(32'h0), .FB_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: one slot, response lat cycles after the grant, data = addr ^ A5A5_0000.
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = imem_rvalid ? (pend_addr ^ 32'hA5A5_0000) : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_addr <= 32'h0;
      cnt       <= 0;
      n_grants  <= 0;
    end else if (imem_req && imem_gnt) begin
      pend      <= 1'b1;
      pend_addr <= imem_addr;
      cnt       <= lat - 1;
      n_grants  <= n_grants + 1;
    end else if (imem_rvalid) begin
      pend <= 1'b0;
    end else if (pend && cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    lat = l;
    id_ready = rdy;
    gnt_en = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (!if_valid && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(tag, {31'h0, if_valid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    // 1: reset state, then back-to-back streaming with zero-wait memory
    lat = 1; id_ready = 1'b1; gnt_en = 1'b1; reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_req",   {31'h0, imem_req}, 32'h0);
    check("rst_pc",    if_pc,    32'h0);
    check("rst_instr", if_instr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t1_req0",  {31'h0, imem_req}, 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    @(negedge clk); #1;
    check("t1_addr1",  imem_addr, 32'h4);
    check("t1_valid1", {31'h0, if_valid}, 32'h0);
    @(negedge clk); #1;
    check("t1_addr2",  imem_addr, 32'h8);
    check("t1_valid2", {31'h0, if_valid}, 32'h1);
    check("t1_pc0",    if_pc, 32'h0);
    check("t1_instr0", if_instr, 32'hA5A5_0000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      check("t1_pc_stream", if_pc, 32'(4 * k));
      check("t1_instr_stream", if_instr, 32'(4 * k) ^ 32'hA5A5_0000);
    end

    // 2: decode stalled from reset fills exactly two entries
    do_reset(1, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    check("t2_grants", 32'(n_grants), 32'd2);
    check("t2_req_full", {31'h0, imem_req}, 32'h0);
    check("t2_pc_hold", if_pc, 32'h0);
    id_ready = 1'b1;
    #1;
    check("t2_req_on_pop", {31'h0, imem_req}, 32'h1);
    check("t2_addr_on_pop", imem_addr, 32'h8);
    check("t2_pc_first", if_pc, 32'h0);
    @(negedge clk); #1;
    check("t2_pc_second", if_pc, 32'h4);

    // 3: redirect while a slow response is pending
    do_reset(3, 1'b1);
    t = 0;
    while (n_grants < 3 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("t3_reach_g8", 32'(n_grants), 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("t3_req_redir", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t3_flushed", {31'h0, if_valid}, 32'h0);
    t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("t3_quiet_cycles", 32'(t), 32'd2);
    check("t3_addr_tgt", imem_addr, 32'h100);
    wait_valid("t3_wait_valid");
    check("t3_pc_tgt", if_pc, 32'h100);
    check("t3_instr_tgt", if_instr, 32'hA5A5_0100);

    // 4: redirect coincides with rvalid
    do_reset(1, 1'b1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("t4_req_redir", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t4_req_next", {31'h0, imem_req}, 32'h1);
    check("t4_addr_next", imem_addr, 32'h40);
    check("t4_dropped", {31'h0, if_valid}, 32'h0);
    wait_valid("t4_wait_valid");
    check("t4_pc_tgt", if_pc, 32'h40);

    // 5: grant withheld, address must hold; misaligned redirect target
    do_reset(1, 1'b1);
    @(negedge clk);
    gnt_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_req_hold", {31'h0, imem_req}, 32'h1);
      check("t5_addr_hold", imem_addr, 32'h4);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    #1;
    check("t5_addr_pregnt", imem_addr, 32'h4);
    @(negedge clk); #1;
    check("t5_addr_post", imem_addr, 32'h8);
    check("t5_grants", 32'(n_grants), 32'd2);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t5_addr_align", imem_addr, 32'h100);
    check("t5_req_align", {31'h0, imem_req}, 32'h1);

    // 6: asynchronous reset with two entries buffered
    do_reset(1, 1'b0);
    repeat (6) @(negedge clk);
    id_ready = 1'b1;
    #1;
    check("t6_pre_valid", {31'h0, if_valid}, 32'h1);
    check("t6_pre_req", {31'h0, imem_req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_async", {31'h0, if_valid}, 32'h0);
    check("t6_req_async", {31'h0, imem_req}, 32'h0);
    check("t6_pc_async", if_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_addr_rst", imem_addr, 32'h0);
    check("t6_req_rst", {31'h0, imem_req}, 32'h1);
    @(negedge clk); #1;
    check("t6_addr_next", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
